// File: rtl/vga_frame_capture.sv
// vga_frame_capture: VGA receive side. Tracks column/row from h_sync/v_sync,
// writes a WIN_W x WIN_H window of RGB332 pixels into the image RAM in raster
// order, and reports measured line length / lines per frame.
// Optional: define VGA_CAPTURE_CHECK_EN to compare the measured periods against
// LINE_PERIOD/FRAME_PERIOD, drive a sticky timing_err and abort a capture on mismatch.
module vga_frame_capture #(
  parameter int WIN_X        = 144,
  parameter int WIN_Y        = 35,
  parameter int WIN_W        = 200,
  parameter int WIN_H        = 200,
  parameter int LINE_PERIOD  = 800,
  parameter int FRAME_PERIOD = 525
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [7:0]  rgb_in,
  input  logic        arm,
  input  logic        cont,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        timing_err
);

  localparam logic [10:0] X_LO = 11'(WIN_X);
  localparam logic [10:0] X_HI = 11'(WIN_X + WIN_W - 1);
  localparam logic [9:0]  Y_LO = 10'(WIN_Y);
  localparam logic [9:0]  Y_HI = 10'(WIN_Y + WIN_H - 1);
  localparam logic [15:0] LAST = 16'(WIN_W * WIN_H - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;
  state_t state, state_nxt;

  logic        hs_q, vs_q;
  logic [10:0] col_q, col_cur;
  logic [9:0]  row_q, row_cur;
  logic        hs_rise, fs, in_win, last_wr, abort_now, mismatch;

  assign hs_rise = h_sync_in & ~hs_q;
  // v_sync only counts at a line start, so a frame always begins on row 1
  assign fs      = hs_rise & v_sync_in & ~vs_q;

  // Position of the pixel on the bus this cycle (column 1 = h_sync rise cycle)
  always_comb begin
    col_cur = (col_q == 11'h7FF) ? col_q : col_q + 11'd1;
    row_cur = row_q;
    if (hs_rise) begin
      col_cur = 11'd1;
      if (fs)                  row_cur = 10'd1;
      else if (row_q != 10'h3FF) row_cur = row_q + 10'd1;
    end
  end

  assign in_win     = (col_cur >= X_LO) && (col_cur <= X_HI) &&
                      (row_cur >= Y_LO) && (row_cur <= Y_HI);
  assign last_wr    = wr_en && (wr_addr == LAST);
  assign frame_done = last_wr;
  assign busy       = (state != IDLE);
  // Last write wins over a coincident frame start / period error
  assign abort_now  = (state == CAPTURE) && !last_wr && (fs || mismatch);

`ifdef VGA_CAPTURE_CHECK_EN
  logic line_seen, frame_seen;

  // First rise and first frame start after reset have no valid previous period
  assign mismatch = (hs_rise && line_seen  && (col_q != 11'(LINE_PERIOD))) ||
                    (fs      && frame_seen && (row_q != 10'(FRAME_PERIOD)));

  // Period checker history and sticky error
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_seen  <= 1'b0;
      frame_seen <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      line_seen  <= line_seen | hs_rise;
      frame_seen <= frame_seen | fs;
      timing_err <= timing_err | mismatch;
    end
  end
`else
  assign mismatch   = 1'b0;
  assign timing_err = 1'b0;
`endif

  // Sync edge detection, raster counters and period measurement
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      hs_q  <= h_sync_in;
      col_q <= col_cur;
      row_q <= row_cur;
      if (hs_rise) begin
        vs_q     <= v_sync_in;
        line_len <= col_q;
      end
      if (fs) frame_lines <= row_q;
    end
  end

  // Capture FSM state register
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (arm) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (fs)  state_nxt = CAPTURE;
      CAPTURE: begin
        if (last_wr)       state_nxt = cont ? WAIT_FRAME : IDLE;
        else if (mismatch) state_nxt = WAIT_FRAME;
      end
      default:             state_nxt = IDLE;
    endcase
  end

  // Write port: one-cycle registered copy of in-window pixels, running address
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_data     <= '0;
      wr_addr     <= '0;
      frame_abort <= 1'b0;
    end else begin
      wr_en       <= (state == CAPTURE) && (state_nxt == CAPTURE) && in_win;
      wr_data     <= rgb_in;
      frame_abort <= abort_now;
      if (((state == WAIT_FRAME) && fs) || abort_now) wr_addr <= '0;
      else if (wr_en)                                  wr_addr <= last_wr ? '0 : wr_addr + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture with a shrunken raster (20 clk x 10 line frame,
// 8x4 window at col 6,row 3). Pixels are random; expected writes are derived
// from window geometry and which frames the directed steps intend to capture.
module tb_vga_frame_capture;
  localparam int WX = 6, WY = 3, WW = 8, WH = 4, LP = 20, FP = 10;
  localparam int N = WW * WH;
`ifdef VGA_CAPTURE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        vga_clk, rst_n, h_sync_in, v_sync_in, arm, cont;
  logic [7:0]  rgb_in;
  logic        wr_en, busy, frame_done, frame_abort, timing_err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  int vectors = 0, errs = 0;
  int idx = 0, prev_len = -1, prev_lines = 0;
  int wr_seen = 0, done_seen = 0;
  bit exp_terr = 1'b0;

  vga_frame_capture #(.WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH),
                      .LINE_PERIOD(LP), .FRAME_PERIOD(FP)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .rgb_in(rgb_in), .arm(arm), .cont(cont), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort),
    .line_len(line_len), .frame_lines(frame_lines), .timing_err(timing_err));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock; the write for this pixel must be visible right after the edge
  task automatic step(input logic hs, input logic vs, input logic [7:0] rgb,
                      input bit ew, input bit ab);
    h_sync_in = hs; v_sync_in = vs; rgb_in = rgb;
    @(posedge vga_clk); #1;
    arm = 1'b0;
    chk("wr_en", wr_en, ew);
    if (ew) begin
      chk("wr_addr", wr_addr, idx);
      chk("wr_data", wr_data, rgb);
    end
    chk("frame_done", frame_done, ew && (idx == N - 1));
    chk("frame_abort", frame_abort, ab);
    if (wr_en)      wr_seen++;
    if (frame_done) done_seen++;
    if (ew)         idx++;
  endtask

  // Drive one frame of nlines lines; optional arm pulse, long line, early stop
  task automatic run_frame(input bit cap, input int nlines, input int arm_line,
                           input int arm_col, input bit ab, input int long_line,
                           input int stop_idx);
    int len;
    bit ew;
    if (cap) idx = 0;
    for (int r = 1; r <= nlines; r++) begin
      len = (r == long_line) ? LP + 1 : LP;
      for (int c = 1; c <= len; c++) begin
        arm = (r == arm_line) && (c == arm_col);
        ew  = cap && (c >= WX) && (c <= WX + WW - 1) && (r >= WY) && (r <= WY + WH - 1);
        step(c <= 2, r <= 2, 8'($urandom_range(0, 255)), ew, ab && r == 1 && c == 1);
        if (c == 1 && prev_len >= 0) chk("line_len", line_len, prev_len);
        if (c == 1 && r == 1)        chk("frame_lines", frame_lines, prev_lines);
        if (stop_idx >= 0 && idx == stop_idx) return;
      end
      prev_len = len;
    end
    prev_lines = nlines;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_abort"}, frame_abort, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_timing_err"}, timing_err, 0);
  endtask

  initial begin
    int w0, d0;
    rst_n = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; rgb_in = '0; arm = 1'b0; cont = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Free-running link, nothing armed: no writes
    run_frame(0, FP, 0, 0, 0, 0, -1);
    run_frame(0, FP, 0, 0, 0, 0, -1);
    chk("idle_busy", busy, 0);

    // Arm mid-frame: current frame skipped, next one captured, then IDLE
    run_frame(0, FP, 4, 7, 0, 0, -1);
    chk("armed_busy", busy, 1);
    w0 = wr_seen; d0 = done_seen;
    run_frame(1, FP, 0, 0, 0, 0, -1);
    chk("single_writes", wr_seen - w0, N);
    chk("single_done", done_seen - d0, 1);
    chk("single_busy", busy, 0);
    run_frame(0, FP, 0, 0, 0, 0, -1);

    // Continuous mode over 3 frames, cont dropped before the third
    cont = 1'b1;
    run_frame(0, FP, 2, 3, 0, 0, -1);
    w0 = wr_seen; d0 = done_seen;
    run_frame(1, FP, 0, 0, 0, 0, -1);
    run_frame(1, FP, 0, 0, 0, 0, -1);
    chk("cont_busy", busy, 1);
    cont = 1'b0;
    run_frame(1, FP, 0, 0, 0, 0, -1);
    run_frame(0, FP, 0, 0, 0, 0, -1);
    chk("cont_writes", wr_seen - w0, 3 * N);
    chk("cont_done", done_seen - d0, 3);
    chk("cont_busy_end", busy, 0);

    // Arm on the frame-start cycle: that frame is not captured
    run_frame(0, FP, 1, 1, 0, 0, -1);
    run_frame(1, FP, 0, 0, 0, 0, -1);
    chk("coinc_busy", busy, 0);

    // One long line while idle: measured as LP+1
    run_frame(0, FP, 0, 0, 0, 5, -1);
    exp_terr = CHK;
    chk("long_terr", timing_err, exp_terr);
    run_frame(0, FP, 0, 0, 0, 0, -1);
    chk("long_terr_sticky", timing_err, exp_terr);

    // Frame restarted after 4 lines mid-capture: abort pulse, address restarts
    run_frame(0, FP, 3, 2, 0, 0, -1);
    w0 = wr_seen;
    run_frame(1, 4, 0, 0, 0, 0, -1);
    chk("partial_writes", wr_seen - w0, 2 * WW);
    d0 = done_seen;
    // With the period checker the short frame also bounces capture to the next frame
    run_frame(!CHK, FP, 0, 0, 1, 0, -1);
    run_frame(CHK, FP, 0, 0, 0, 0, -1);
    chk("abort_recover_done", done_seen - d0, 1);
    chk("abort_terr", timing_err, exp_terr);

    // Async reset halfway through a capture
    run_frame(0, FP, 2, 9, 0, 0, -1);
    run_frame(1, FP, 0, 0, 0, 0, N / 2);
    chk("pre_reset_addr", wr_addr, N / 2 - 1);
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    #2 rst_n = 1'b1;
    prev_len = -1; prev_lines = 0; exp_terr = 1'b0;
    w0 = wr_seen;
    run_frame(0, FP, 2, 4, 0, 0, -1);
    run_frame(1, FP, 0, 0, 0, 0, -1);
    chk("rearm_writes", wr_seen - w0, N);
    chk("rearm_done", done_seen - d0, 1);
    chk("rearm_terr", timing_err, exp_terr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
